// File: rtl/alu_ctrl_seq_pkg.sv
// Shared encodings for the execute-stage ALU control and its mult/div sequencer:
// ALU operation codes, funct/ALUOp codes, HI/LO select codes and FSM states.
package alu_ctrl_seq_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_ALU3 = 4'b1110;
  localparam logic [3:0] OP_BAD  = 4'b1111;

  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_XOR   = 6'b100110;
  localparam logic [5:0] FUNCT_NOR   = 6'b100111;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_SLTU  = 6'b101011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OTHER = 2'b11;

  localparam logic [1:0] HILO_SEL_ALU = 2'b00;
  localparam logic [1:0] HILO_SEL_HI  = 2'b01;
  localparam logic [1:0] HILO_SEL_LO  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } md_state_e;

endpackage

// File: rtl/alu_ctrl_seq_funct_decode.sv
// Stateless decode of ALUOp/funct into the ALU operation code, the HI/LO result
// select and a flag marking mult/multu/div/divu.
module alu_funct_decode
  import alu_ctrl_seq_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic [1:0]      alu_op,
  input  logic [5:0]      funct,
  output logic [OP_W-1:0] operation,
  output logic [1:0]      hilo_sel,
  output logic            is_md
);

  logic [3:0] op4;

  always_comb begin
    op4      = OP_BAD;
    hilo_sel = HILO_SEL_ALU;
    is_md    = 1'b0;
    unique case (alu_op)
      ALUOP_ADD:   op4 = OP_ADD;
      ALUOP_SUB:   op4 = OP_SUB;
      ALUOP_OTHER: op4 = OP_ALU3;
      default: begin
        case (funct)
          FUNCT_ADD, FUNCT_ADDU: op4 = OP_ADD;
          FUNCT_SUB, FUNCT_SUBU: op4 = OP_SUB;
          FUNCT_AND:             op4 = OP_AND;
          FUNCT_OR:              op4 = OP_OR;
          FUNCT_XOR:             op4 = OP_XOR;
          FUNCT_NOR:             op4 = OP_NOR;
          FUNCT_SLT:             op4 = OP_SLT;
          FUNCT_SLTU:            op4 = OP_SLTU;
          default:               op4 = OP_BAD;
        endcase
        if (funct == FUNCT_MFHI) hilo_sel = HILO_SEL_HI;
        if (funct == FUNCT_MFLO) hilo_sel = HILO_SEL_LO;
        is_md = (funct[5:2] == FUNCT_MULT[5:2]);
      end
    endcase
  end

  // Upper bits of a widened operation code are always zero.
  assign operation = OP_W'(op4);

endmodule

// File: rtl/alu_ctrl_seq.sv
// Execute-stage ALU control with a fixed-latency mult/div sequencer that stalls the
// core, steps the HI/LO datapath and pulses the HI/LO write once the op completes.
module alu_ctrl_seq
  import alu_ctrl_seq_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  input  logic [1:0]      alu_op,
  input  logic [5:0]      funct,
  output logic [OP_W-1:0] operation,
  output logic [1:0]      hilo_sel,
  output logic            stall,
  output logic            md_start,
  output logic            md_step,
  output logic            md_is_div,
  output logic            md_signed,
  output logic            hilo_we
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_LAT - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             signed_q, signed_d;
  logic             is_md;
  logic             accept;

  alu_funct_decode #(.OP_W(OP_W)) u_decode (
    .alu_op    (alu_op),
    .funct     (funct),
    .operation (operation),
    .hilo_sel  (hilo_sel),
    .is_md     (is_md)
  );

  assign accept = valid && is_md;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      signed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      signed_q <= signed_d;
    end
  end

  // Control pulses are suppressed while reset is held so an aborted op never writes HI/LO.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    signed_d = signed_q;
    stall    = 1'b0;
    md_start = 1'b0;
    md_step  = 1'b0;
    hilo_we  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          md_start = 1'b1;
          stall    = 1'b1;
          is_div_d = funct[1];
          signed_d = ~funct[0];
          cnt_d    = funct[1] ? DIV_INIT : MUL_INIT;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall   = 1'b1;
        md_step = 1'b1;
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_DONE: begin
        hilo_we = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst) begin
      stall    = 1'b0;
      md_start = 1'b0;
      md_step  = 1'b0;
      hilo_we  = 1'b0;
    end
  end

  assign md_is_div = is_div_d;
  assign md_signed = signed_d;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: directed scenarios then random traffic,
// compared each cycle against a timeline model of the mult/div sequencing.
module tb_alu_ctrl_seq;

  localparam int OP_W    = 4;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid;
  logic [1:0]      alu_op;
  logic [5:0]      funct;
  logic [OP_W-1:0] operation;
  logic [1:0]      hilo_sel;
  logic            stall, md_start, md_step, md_is_div, md_signed, hilo_we;

  int checks = 0;
  int fails  = 0;

  // Timeline model: an accepted md op at cycle t_acc occupies lat+2 cycles.
  int cyc = 0;
  bit md_active = 1'b0;
  int t_acc = 0;
  int lat = 0;
  bit m_div = 1'b0;
  bit m_sgn = 1'b0;

  always #5 clk = ~clk;

  alu_ctrl_seq #(.OP_W(OP_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid     (valid),
    .alu_op    (alu_op),
    .funct     (funct),
    .operation (operation),
    .hilo_sel  (hilo_sel),
    .stall     (stall),
    .md_start  (md_start),
    .md_step   (md_step),
    .md_is_div (md_is_div),
    .md_signed (md_signed),
    .hilo_we   (hilo_we)
  );

  function automatic logic [3:0] ref_op(input logic [1:0] a, input logic [5:0] f);
    if (a == 2'd0) return 4'd2;
    if (a == 2'd1) return 4'd6;
    if (a == 2'd3) return 4'd14;
    case (f)
      6'd32, 6'd33: return 4'd2;
      6'd34, 6'd35: return 4'd6;
      6'd36:        return 4'd0;
      6'd37:        return 4'd1;
      6'd38:        return 4'd3;
      6'd39:        return 4'd12;
      6'd42:        return 4'd7;
      6'd43:        return 4'd8;
      default:      return 4'd15;
    endcase
  endfunction

  function automatic logic [1:0] ref_hilo(input logic [1:0] a, input logic [5:0] f);
    if (a == 2'd2 && f == 6'd16) return 2'd1;
    if (a == 2'd2 && f == 6'd18) return 2'd2;
    return 2'd0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check every output against the model, advance one clock.
  task automatic applyStimulus(input bit r, input bit v, input logic [1:0] a, input logic [5:0] f);
    bit e_start, e_stall, e_step, e_we, chk_attr;
    int k;
    rst = r; valid = v; alu_op = a; funct = f;
    #1;
    e_start = 0; e_stall = 0; e_step = 0; e_we = 0; chk_attr = 0;
    k = cyc - t_acc;
    if (r) begin
      md_active = 0;
    end else if (md_active) begin
      e_stall  = (k <= lat);
      e_step   = (k >= 1 && k <= lat);
      e_we     = (k == lat + 1);
      chk_attr = e_stall;
      if (k == lat + 1) md_active = 0;
    end else if (v && a == 2'd2 && f >= 6'd24 && f <= 6'd27) begin
      e_start   = 1; e_stall = 1; chk_attr = 1;
      md_active = 1; t_acc = cyc;
      m_div     = f[1];
      m_sgn     = ~f[0];
      lat       = m_div ? DIV_LAT : MUL_LAT;
    end
    checkOutput("operation", 32'(operation), 32'(ref_op(a, f)));
    checkOutput("hilo_sel",  32'(hilo_sel),  32'(ref_hilo(a, f)));
    checkOutput("stall",     32'(stall),     32'(e_stall));
    checkOutput("md_start",  32'(md_start),  32'(e_start));
    checkOutput("md_step",   32'(md_step),   32'(e_step));
    checkOutput("hilo_we",   32'(hilo_we),   32'(e_we));
    checkOutput("onehot_pulses", 32'(md_start + md_step + hilo_we) <= 1 ? 32'd1 : 32'd0, 32'd1);
    if (chk_attr) begin
      checkOutput("md_is_div", 32'(md_is_div), 32'(m_div));
      checkOutput("md_signed", 32'(md_signed), 32'(m_sgn));
    end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    logic [5:0] rtype [10];
    logic [5:0] rf;
    rtype = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd43};
    rst = 1; valid = 0; alu_op = 0; funct = 0;
    @(negedge clk);

    // Reset, then decode sweep
    applyStimulus(1, 0, 2'd0, 6'd0);
    applyStimulus(1, 1, 2'd2, 6'd24);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 2'd2, rtype[i]);
    applyStimulus(0, 1, 2'd2, 6'd31);
    applyStimulus(0, 1, 2'd0, 6'd43);
    applyStimulus(0, 1, 2'd1, 6'd43);
    applyStimulus(0, 1, 2'd3, 6'd43);
    applyStimulus(0, 1, 2'd2, 6'd16);
    applyStimulus(0, 1, 2'd2, 6'd18);
    applyStimulus(0, 1, 2'd1, 6'd18);

    // mult: full latency window plus idle tail
    for (int i = 0; i < MUL_LAT + 4; i++) applyStimulus(0, 1, 2'd2, (i == 0) ? 6'd24 : 6'd32);

    // divu with funct wandering during BUSY
    applyStimulus(0, 1, 2'd2, 6'd27);
    for (int i = 0; i < DIV_LAT + 3; i++) applyStimulus(0, 1, 2'd2, 6'($urandom_range(0, 63)));

    // div immediately followed by mflo held until it retires
    applyStimulus(0, 1, 2'd2, 6'd26);
    for (int i = 0; i < DIV_LAT + 4; i++) applyStimulus(0, 1, 2'd2, 6'd18);

    // reset during BUSY cycle 2, then a fresh mult
    applyStimulus(0, 1, 2'd2, 6'd25);
    applyStimulus(0, 1, 2'd2, 6'd25);
    applyStimulus(1, 1, 2'd2, 6'd25);
    applyStimulus(0, 0, 2'd2, 6'd25);
    for (int i = 0; i < MUL_LAT + 3; i++) applyStimulus(0, 1, 2'd2, (i == 0) ? 6'd24 : 6'd0);

    // no accept without valid or without R-type ALUOp
    applyStimulus(0, 0, 2'd2, 6'd24);
    applyStimulus(0, 1, 2'd0, 6'd24);
    applyStimulus(0, 0, 2'd2, 6'd26);

    // random traffic biased toward md functs
    for (int i = 0; i < 600; i++) begin
      rf = ($urandom_range(0, 2) == 0) ? 6'(24 + $urandom_range(0, 3)) : 6'($urandom_range(0, 63));
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'd2, rf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
